titan_spi_arbiter: RTL and testbench

//  Round-robin arbiter and SPI master sequencer that shares the titan SPI slave port between two
//  on-chip requesters (req 0: Wishbone bridge, req 1: logic-analyser command path).

---
 rtl/titan_spi_pkg.sv | 25 ++
 rtl/titan_spi_clkgen.sv | 51 +++++
 rtl/titan_spi_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_titan_spi_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/titan_spi_pkg.sv
// Shared types and constants for the titan SPI arbiter: FSM states, default field
// widths, titan opcodes and the requester one-hot helper.
package titan_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam int CMD_W_DEF   = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;

    localparam logic [7:0] TITAN_OP_WRITE  = 8'h02;
    localparam logic [7:0] TITAN_OP_READ   = 8'h03;
    localparam logic [7:0] TITAN_OP_STATUS = 8'h05;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/titan_spi_clkgen.sv
// Phase timer for the SPI sequencer: counts CLK_DIV system cycles per phase and
// tracks which SCLK half is active while shifting.
module titan_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic shift,
    output logic rise,
    output logic fall,
    output logic phase_done,
    output logic half,
    output logic half_next
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;
    logic       half_r;

    // Strobes: rise marks the first high cycle, fall the last high cycle of a bit.
    always_comb begin
        phase_done = run && (cnt_r == DIV_LAST);
        rise       = shift && !half_r && (cnt_r == 8'd0);
        fall       = shift && !half_r && (cnt_r == DIV_LAST);
        if (shift) begin
            half_next = half_r ^ phase_done;
        end else begin
            half_next = 1'b0;
        end
    end

    // Phase counter restarts at zero whenever the sequencer is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 8'd0;
            half_r <= 1'b0;
        end else begin
            half_r <= half_next;
            if (!run || (cnt_r == DIV_LAST)) begin
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    assign half = half_r;

endmodule

// File: rtl/titan_spi_arbiter.sv
// Round-robin arbiter sharing the titan SPI slave between two requesters; runs one
// CMD+DATA mode-0 frame per grant and returns the last DATA_W bits sampled on POCI.
module titan_spi_arbiter
    import titan_spi_pkg::*;
#(
    parameter int CMD_W   = CMD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_i,
    input  logic [1:0]            req_valid_i,
    input  logic [2*CMD_W-1:0]    req_cmd_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  busy_o,
    output logic                  spi_clock_o,
    output logic                  spi_cs_o,
    output logic                  spi_pico_o,
    input  logic                  spi_poci_i
);

    localparam int NB  = CMD_W + DATA_W;
    localparam int BCW = $clog2(NB);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NB - 1);

    spi_state_e        state_r;
    spi_state_e        state_s;
    logic              ptr_r;
    logic              gidx_r;
    logic              gidx_s;
    logic              grant_s;
    logic [CMD_W-1:0]  cmd_s;
    logic [DATA_W-1:0] wdata_s;
    logic [NB-1:0]     shout_r;
    logic [DATA_W-1:0] shin_r;
    logic [BCW-1:0]    bitcnt_r;
    logic              cs_r;
    logic              sclk_r;
    logic              pico_r;
    logic [1:0]        rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              cs_next_s;
    logic              sclk_next_s;
    logic              run_s;
    logic              shift_s;
    logic              bit_end_s;
    logic              rise_s;
    logic              fall_s;
    logic              phase_done_s;
    logic              half_s;
    logic              half_next_s;

    assign run_s   = (state_r != ST_IDLE);
    assign shift_s = (state_r == ST_SHIFT);

    titan_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk        (sys_clock_i),
        .rst        (sys_reset_i),
        .run        (run_s),
        .shift      (shift_s),
        .rise       (rise_s),
        .fall       (fall_s),
        .phase_done (phase_done_s),
        .half       (half_s),
        .half_next  (half_next_s)
    );

    // Arbitration: pointer-preferred requester wins; reset masks the grant.
    always_comb begin
        if (req_valid_i[ptr_r]) begin
            gidx_s = ptr_r;
        end else begin
            gidx_s = ~ptr_r;
        end
        grant_s = !sys_reset_i && (state_r == ST_IDLE) && (req_valid_i != 2'b00);
        if (gidx_s) begin
            cmd_s   = req_cmd_i[2*CMD_W-1:CMD_W];
            wdata_s = req_wdata_i[2*DATA_W-1:DATA_W];
        end else begin
            cmd_s   = req_cmd_i[CMD_W-1:0];
            wdata_s = req_wdata_i[DATA_W-1:0];
        end
        if (grant_s) begin
            req_ready_o = req_onehot(gidx_s);
        end else begin
            req_ready_o = 2'b00;
        end
        busy_o = grant_s || run_s;
    end

    assign bit_end_s = phase_done_s && half_s;

    // Next-state logic plus next values of the registered SPI pins.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_s = ST_SETUP;
                else         state_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (phase_done_s) state_s = ST_SHIFT;
                else              state_s = ST_SETUP;
            end
            ST_SHIFT: begin
                if (bit_end_s && (bitcnt_r == BIT_LAST)) state_s = ST_HOLD;
                else                                     state_s = ST_SHIFT;
            end
            ST_HOLD: begin
                if (phase_done_s) state_s = ST_GAP;
                else              state_s = ST_HOLD;
            end
            ST_GAP: begin
                if (phase_done_s) state_s = ST_IDLE;
                else              state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
        cs_next_s   = !((state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_HOLD));
        sclk_next_s = (state_s == ST_SHIFT) && !half_next_s;
    end

    // FSM state, round-robin pointer and the owner of the current frame.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state_r <= ST_IDLE;
            ptr_r   <= 1'b0;
            gidx_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                ptr_r  <= ~gidx_s;
                gidx_r <= gidx_s;
            end
        end
    end

    // Shift-out, shift-in and bit counter; the request is captured only at grant.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            shout_r  <= {NB{1'b0}};
            shin_r   <= {DATA_W{1'b0}};
            bitcnt_r <= {BCW{1'b0}};
        end else begin
            if (grant_s) begin
                shout_r <= {cmd_s, wdata_s};
            end else if (fall_s) begin
                shout_r <= {shout_r[NB-2:0], 1'b0};
            end
            if (rise_s) begin
                shin_r <= {shin_r[DATA_W-2:0], spi_poci_i};
            end
            if (grant_s) begin
                bitcnt_r <= {BCW{1'b0}};
            end else if (shift_s && bit_end_s) begin
                bitcnt_r <= bitcnt_r + BCW'(1);
            end
        end
    end

    // Registered pins and the completion pulse raised on entry to the gap.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            cs_r        <= 1'b1;
            sclk_r      <= 1'b0;
            pico_r      <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            cs_r   <= cs_next_s;
            sclk_r <= sclk_next_s;
            if (grant_s) begin
                pico_r <= cmd_s[CMD_W-1];
            end else if (fall_s) begin
                pico_r <= shout_r[NB-2];
            end
            if ((state_r == ST_HOLD) && (state_s == ST_GAP)) begin
                rsp_valid_r <= req_onehot(gidx_r);
                rsp_rdata_r <= shin_r;
            end else begin
                rsp_valid_r <= 2'b00;
            end
        end
    end

    assign spi_cs_o    = cs_r;
    assign spi_clock_o = sclk_r;
    assign spi_pico_o  = pico_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;

endmodule

// File: tb/tb_titan_spi_arbiter.sv
// Scoreboard bench for titan_spi_arbiter: CLK_DIV=4 instance plus a CLK_DIV=2 instance,
// each with a mode-0 titan slave model.
module tb_titan_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_valid_i = 2'b00;
    logic [15:0] req_cmd_i   = 16'h0000;
    logic [31:0] req_wdata_i = 32'h0;
    logic [1:0]  req_ready_o, rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        busy_o, spi_clock_o, spi_cs_o, spi_pico_o;
    logic        spi_poci_i = 1'b0;

    logic [1:0]  b_valid = 2'b00;
    logic [15:0] b_cmd   = 16'h0000;
    logic [31:0] b_wdata = 32'h0;
    logic [1:0]  b_ready, b_rsp_valid;
    logic [15:0] b_rdata;
    logic        b_busy, b_sclk, b_cs, b_pico;
    logic        b_poci = 1'b0;

    titan_spi_arbiter #(.CMD_W(8), .DATA_W(16), .CLK_DIV(4)) dut (
        .sys_clock_i(clk), .sys_reset_i(rst),
        .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .busy_o(busy_o), .spi_clock_o(spi_clock_o), .spi_cs_o(spi_cs_o),
        .spi_pico_o(spi_pico_o), .spi_poci_i(spi_poci_i)
    );

    titan_spi_arbiter #(.CMD_W(8), .DATA_W(16), .CLK_DIV(2)) dut2 (
        .sys_clock_i(clk), .sys_reset_i(rst),
        .req_valid_i(b_valid), .req_cmd_i(b_cmd), .req_wdata_i(b_wdata),
        .req_ready_o(b_ready), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata),
        .busy_o(b_busy), .spi_clock_o(b_sclk), .spi_cs_o(b_cs),
        .spi_pico_o(b_pico), .spi_poci_i(b_poci)
    );

    typedef struct { logic [1:0] oh; int gap; } grant_t;
    typedef struct { logic [1:0] oh; logic [15:0] data; } rsp_t;

    grant_t      gq[$];
    rsp_t        rq[$];
    rsp_t        b_rq[$];
    logic [23:0] fq[$];
    logic [23:0] b_fq[$];
    logic [15:0] sq[$];
    logic [15:0] b_sq[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tmo_cnt = 0;
    logic idle_en = 1'b0;
    logic final_req = 1'b0;
    logic final_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // titan slave model (CLK_DIV=4 instance)
    logic [23:0] s_out = 24'h0, s_in = 24'h0;
    int          s_rise = 0;
    logic        s_cs_p = 1'b1, s_ck_p = 1'b0;
    always @(spi_cs_o or spi_clock_o) begin
        if (spi_cs_o === 1'b0 && s_cs_p !== 1'b0) begin
            s_out = {8'hC3, 16'h0000};
            if (sq.size() > 0) s_out[15:0] = sq.pop_front();
            spi_poci_i = s_out[23];
            s_in = 24'h0;
            s_rise = 0;
        end else if (spi_cs_o === 1'b0 && spi_clock_o === 1'b1 && s_ck_p !== 1'b1) begin
            s_in = {s_in[22:0], spi_pico_o};
            s_rise++;
        end else if (spi_cs_o === 1'b0 && spi_clock_o === 1'b0 && s_ck_p === 1'b1) begin
            s_out = {s_out[22:0], 1'b0};
            spi_poci_i = s_out[23];
        end
        s_cs_p = spi_cs_o;
        s_ck_p = spi_clock_o;
    end

    // titan slave model (CLK_DIV=2 instance)
    logic [23:0] t_out = 24'h0, t_in = 24'h0;
    int          t_rise = 0;
    logic        t_cs_p = 1'b1, t_ck_p = 1'b0;
    always @(b_cs or b_sclk) begin
        if (b_cs === 1'b0 && t_cs_p !== 1'b0) begin
            t_out = {8'h3C, 16'h0000};
            if (b_sq.size() > 0) t_out[15:0] = b_sq.pop_front();
            b_poci = t_out[23];
            t_in = 24'h0;
            t_rise = 0;
        end else if (b_cs === 1'b0 && b_sclk === 1'b1 && t_ck_p !== 1'b1) begin
            t_in = {t_in[22:0], b_pico};
            t_rise++;
        end else if (b_cs === 1'b0 && b_sclk === 1'b0 && t_ck_p === 1'b1) begin
            t_out = {t_out[22:0], 1'b0};
            b_poci = t_out[23];
        end
        t_cs_p = b_cs;
        t_ck_p = b_sclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: pops scoreboard entries whenever the DUTs present grants, responses or frames
    int     last_grant = 0, cs_low = 0, b_last_grant = 0, b_cs_low = 0;
    logic   m_cs_p = 1'b1, m_bcs_p = 1'b1;
    grant_t g;
    rsp_t   r;
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {24'h0, req_ready_o, rsp_valid_o, busy_o, spi_cs_o, spi_clock_o, spi_pico_o}, 32'h04);
            chk("reset_outputs_div2", {24'h0, b_ready, b_rsp_valid, b_busy, b_cs, b_sclk, b_pico}, 32'h04);
            cs_low = 0;
            b_cs_low = 0;
        end else begin
            if (idle_en)
                chk("idle_outputs", {24'h0, req_ready_o, rsp_valid_o, busy_o, spi_cs_o, spi_clock_o, spi_pico_o}, 32'h04);
            if (req_ready_o != 2'b00) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {30'h0, req_ready_o}, 32'h0);
                end else begin
                    g = gq.pop_front();
                    chk("grant_onehot", {30'h0, req_ready_o}, {30'h0, g.oh});
                    chk("busy_at_grant", {31'h0, busy_o}, 32'h1);
                    if (g.gap > 0) chk("grant_spacing", cyc - last_grant, g.gap);
                end
                last_grant = cyc;
            end
            if (rsp_valid_o != 2'b00) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", {30'h0, rsp_valid_o}, 32'h0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_valid_idx", {30'h0, rsp_valid_o}, {30'h0, r.oh});
                    chk("rsp_rdata", {16'h0, rsp_rdata_o}, {16'h0, r.data});
                    chk("rsp_latency", cyc - last_grant, 201);
                end
            end
            if (m_cs_p == 1'b0 && spi_cs_o == 1'b1) begin
                if (fq.size() == 0) chk("unexpected_frame", 32'h1, 32'h0);
                else                chk("pico_frame", {8'h0, s_in}, {8'h0, fq.pop_front()});
                chk("sclk_rises", s_rise, 24);
                chk("cs_low_cycles", cs_low, 200);
            end
            if (!spi_cs_o) cs_low++;
            else           cs_low = 0;

            if (b_ready != 2'b00) begin
                chk("div2_grant", {30'h0, b_ready}, 32'h1);
                b_last_grant = cyc;
            end
            if (b_rsp_valid != 2'b00) begin
                if (b_rq.size() == 0) begin
                    chk("div2_unexpected_rsp", {30'h0, b_rsp_valid}, 32'h0);
                end else begin
                    r = b_rq.pop_front();
                    chk("div2_rsp_idx", {30'h0, b_rsp_valid}, {30'h0, r.oh});
                    chk("div2_rsp_rdata", {16'h0, b_rdata}, {16'h0, r.data});
                    chk("div2_rsp_latency", cyc - b_last_grant, 101);
                end
            end
            if (m_bcs_p == 1'b0 && b_cs == 1'b1) begin
                if (b_fq.size() == 0) chk("div2_unexpected_frame", 32'h1, 32'h0);
                else                  chk("div2_pico_frame", {8'h0, t_in}, {8'h0, b_fq.pop_front()});
                chk("div2_cs_low_cycles", b_cs_low, 100);
            end
            if (!b_cs) b_cs_low++;
            else       b_cs_low = 0;
        end
        m_cs_p  = spi_cs_o;
        m_bcs_p = b_cs;
        if (final_req && !final_done) begin
            chk("pending_grants", gq.size(), 0);
            chk("pending_rsps", rq.size(), 0);
            chk("pending_frames", fq.size(), 0);
            chk("div2_pending_rsps", b_rq.size(), 0);
            chk("div2_pending_frames", b_fq.size(), 0);
            chk("wait_timeouts", tmo_cnt, 0);
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic second, input int idx);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(second ? b_ready[idx] : req_ready_o[idx]) && n < 2000);
        if (n >= 2000) tmo_cnt++;
        step();
    endtask

    task automatic wait_idle(input logic second);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((second ? b_busy : busy_o) && n < 2000);
        if (n >= 2000) tmo_cnt++;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // idle after reset
        idle_en = 1'b1;
        repeat (50) step();
        idle_en = 1'b0;

        // single transfer from requester 0
        gq.push_back('{2'b01, 0});
        rq.push_back('{2'b01, 16'hBEEF});
        fq.push_back({8'hA5, 16'h1234});
        sq.push_back(16'hBEEF);
        req_cmd_i   = 16'h00A5;
        req_wdata_i = 32'h0000_1234;
        req_valid_i = 2'b01;
        wait_ready(1'b0, 0);
        req_valid_i = 2'b00;
        req_cmd_i   = 16'hFFFF;
        req_wdata_i = 32'hDEAD_DEAD;
        wait_idle(1'b0);
        step();

        // continuous contention from reset: strict alternation
        rst = 1'b1;
        req_valid_i = 2'b11;
        req_cmd_i   = {8'h02, 8'h03};
        req_wdata_i = {16'h2222, 16'h1111};
        gq.push_back('{2'b01, 0});
        gq.push_back('{2'b10, 205});
        gq.push_back('{2'b01, 205});
        gq.push_back('{2'b10, 205});
        rq.push_back('{2'b01, 16'hC001});
        rq.push_back('{2'b10, 16'hC002});
        rq.push_back('{2'b01, 16'hC003});
        rq.push_back('{2'b10, 16'hC004});
        fq.push_back({8'h03, 16'h1111});
        fq.push_back({8'h02, 16'h2222});
        fq.push_back({8'h03, 16'h1111});
        fq.push_back({8'h02, 16'h2222});
        sq.push_back(16'hC001);
        sq.push_back(16'hC002);
        sq.push_back(16'hC003);
        sq.push_back(16'hC004);
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 3000 && n < 4; i++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) n++;
        end
        if (n < 4) tmo_cnt++;
        step();
        req_valid_i = 2'b00;
        wait_idle(1'b0);
        step();

        // reset in the middle of SHIFT: frame aborted, no response
        gq.push_back('{2'b01, 0});
        sq.push_back(16'h0BAD);
        req_cmd_i   = 16'h000F;
        req_wdata_i = 32'h0000_AAAA;
        req_valid_i = 2'b01;
        wait_ready(1'b0, 0);
        req_valid_i = 2'b00;
        repeat (99) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();

        // later request from requester 1 completes; a one-cycle req0 pulse while busy is ignored
        gq.push_back('{2'b10, 0});
        rq.push_back('{2'b10, 16'h1357});
        fq.push_back({8'h81, 16'h55AA});
        sq.push_back(16'h1357);
        req_cmd_i   = 16'h8100;
        req_wdata_i = 32'h55AA_0000;
        req_valid_i = 2'b10;
        wait_ready(1'b0, 1);
        req_valid_i = 2'b00;
        repeat (50) step();
        req_valid_i = 2'b01;
        step();
        req_valid_i = 2'b00;
        wait_idle(1'b0);
        repeat (20) step();

        // CLK_DIV=2 instance: 100-cycle frame, response at T+101
        b_rq.push_back('{2'b01, 16'h8001});
        b_fq.push_back({8'h9C, 16'h0F0F});
        b_sq.push_back(16'h8001);
        b_cmd   = 16'h009C;
        b_wdata = 32'h0000_0F0F;
        b_valid = 2'b01;
        wait_ready(1'b1, 0);
        b_valid = 2'b00;
        wait_idle(1'b1);
        repeat (10) step();

        final_req = 1'b1;
        n = 0;
        while (!final_done && n < 10) begin
            step();
            n++;
        end
        if (!final_done) begin
            $display("FAIL final_handshake: monitor did not complete end checks");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
